// File: rtl/d_mem_port_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory (MEM stage vs. DMA).
// Optional grant statistics and starvation event output are enabled with `define DARB_STATS_EN.
module d_mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_lock,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DARB_STATS_EN
    ,
    output logic [15:0]       p0_gnt_cnt,
    output logic [15:0]       p1_gnt_cnt,
    output logic              starve_evt
`endif
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait0;
    logic [WAIT_W-1:0] r_wait1;
    logic              r_p0_rvalid;
    logic              r_p1_rvalid;
    logic              w_starve0;
    logic              w_starve1;
    logic              w_gnt0;
    logic              w_gnt1;

    assign w_starve0 = p0_req && (r_wait0 == WAIT_MAX);
    assign w_starve1 = p1_req && (r_wait1 == WAIT_MAX);

    // A starved requester preempts even a locked owner; at most one port can be starved at once.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_starve1)      w_gnt1 = 1'b1;
                    else if (w_starve0) w_gnt0 = 1'b1;
                    else if (p0_req)    w_gnt0 = 1'b1;
                    else if (p1_req)    w_gnt1 = 1'b1;
                end
                OWN0: begin
                    if (w_starve1)      w_gnt1 = 1'b1;
                    else if (p0_req)    w_gnt0 = 1'b1;
                end
                OWN1: begin
                    if (w_starve0)      w_gnt0 = 1'b1;
                    else if (p1_req)    w_gnt1 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign p0_gnt = w_gnt0;
    assign p1_gnt = w_gnt1;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = p0_addr;
        mem_wdata = p0_wdata;
        if (rst) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (w_gnt1) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end else if (w_gnt0) begin
            mem_we    = p0_we;
        end
    end

    // A forced grant lands via IDLE, so the granted port's own lock decides the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (w_gnt0) begin
            r_state <= p0_lock ? OWN0 : IDLE;
        end else if (w_gnt1) begin
            r_state <= p1_lock ? OWN1 : IDLE;
        end else begin
            r_state <= IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait0 <= '0;
            r_wait1 <= '0;
        end else begin
            if (p0_req && !w_gnt0) r_wait0 <= (r_wait0 == WAIT_MAX) ? WAIT_MAX : r_wait0 + 1'b1;
            else                   r_wait0 <= '0;
            if (p1_req && !w_gnt1) r_wait1 <= (r_wait1 == WAIT_MAX) ? WAIT_MAX : r_wait1 + 1'b1;
            else                   r_wait1 <= '0;
        end
    end

    // Read return: memory answers one cycle after the address, tag it with the granting port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
        end else begin
            r_p0_rvalid <= w_gnt0 && !p0_we;
            r_p1_rvalid <= w_gnt1 && !p1_we;
        end
    end

    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

`ifdef DARB_STATS_EN
    logic [15:0] r_p0_gnt_cnt;
    logic [15:0] r_p1_gnt_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0_gnt_cnt <= '0;
            r_p1_gnt_cnt <= '0;
        end else begin
            if (w_gnt0) r_p0_gnt_cnt <= r_p0_gnt_cnt + 16'd1;
            if (w_gnt1) r_p1_gnt_cnt <= r_p1_gnt_cnt + 16'd1;
        end
    end

    assign p0_gnt_cnt = r_p0_gnt_cnt;
    assign p1_gnt_cnt = r_p1_gnt_cnt;
    assign starve_evt = (w_gnt0 && w_starve0) || (w_gnt1 && w_starve1);
`endif

endmodule

// File: tb/tb_d_mem_port_arbiter.sv
// Directed bench for d_mem_port_arbiter with a behavioural 1-cycle-latency data memory.
module tb_d_mem_port_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic              p0_req, p0_we, p0_lock;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt, p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p1_req, p1_we, p1_lock;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt, p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
`ifdef DARB_STATS_EN
    logic [15:0]       p0_gnt_cnt, p1_gnt_cnt;
    logic              starve_evt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mem [0:255];

    d_mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_lock(p0_lock), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef DARB_STATS_EN
        , .p0_gnt_cnt(p0_gnt_cnt), .p1_gnt_cnt(p1_gnt_cnt), .starve_evt(starve_evt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [7:0] addr,
                          input logic [15:0] wdata, input logic lock);
        p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_lock = lock;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [7:0] addr,
                          input logic [15:0] wdata, input logic lock);
        p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_lock = lock;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hBEEF;
        mem[8'h11] = 16'h1234;
        mem_rdata  = 16'h0000;

        // reset held two cycles with both ports requesting
        rst = 1'b1;
        set_p0(1'b1, 1'b1, 8'h10, 16'hAAAA, 1'b0);
        set_p1(1'b1, 1'b0, 8'h11, 16'h5A5A, 1'b0);
        next_cycle(); #1;
        check("rst_gnt0", p0_gnt, 0);
        check("rst_gnt1", p1_gnt, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        next_cycle();
        check("rst_rv0", p0_rvalid, 0);
        check("rst_rv1", p1_rvalid, 0);

        // first cycle out of reset: p0 read of 0x10
        rst = 1'b0;
        set_p0(1'b1, 1'b0, 8'h10, 16'hAAAA, 1'b0);
        #1;
        check("c0_gnt0", p0_gnt, 1);
        check("c0_gnt1", p1_gnt, 0);
        check("c0_addr", mem_addr, 8'h10);
        check("c0_we", mem_we, 0);

        next_cycle();
        check("c1_rv0", p0_rvalid, 1);
        check("c1_rd0", p0_rdata, 16'hBEEF);
        check("c1_rv1", p1_rvalid, 0);
        p0_req = 1'b0;
        #1;
        check("c1_gnt1", p1_gnt, 1);
        check("c1_gnt0", p0_gnt, 0);
        check("c1_addr", mem_addr, 8'h11);

        // contention: p0 read vs p1 write, no lock
        next_cycle();
        check("c2_rv1", p1_rvalid, 1);
        check("c2_rd1", p1_rdata, 16'h1234);
        check("c2_rv0", p0_rvalid, 0);
        set_p0(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0);
        set_p1(1'b1, 1'b1, 8'h30, 16'h5555, 1'b0);
        #1;
        check("c2_gnt0", p0_gnt, 1);
        check("c2_gnt1", p1_gnt, 0);

        next_cycle();
        check("c3_rv0", p0_rvalid, 1);
        p0_req = 1'b0;
        #1;
        check("c3_gnt1", p1_gnt, 1);
        check("c3_we", mem_we, 1);
        check("c3_addr", mem_addr, 8'h30);
        check("c3_wdata", mem_wdata, 16'h5555);

        // locked 3-beat p1 write, p0 arrives on beat 2
        next_cycle();
        check("c4_rv1", p1_rvalid, 0);
        set_p1(1'b1, 1'b1, 8'h20, 16'hA000, 1'b1);
        #1;
        check("c4_gnt1", p1_gnt, 1);

        next_cycle();
        set_p1(1'b1, 1'b1, 8'h21, 16'hA001, 1'b1);
        set_p0(1'b1, 1'b0, 8'h20, 16'h0000, 1'b0);
        #1;
        check("c5_gnt1", p1_gnt, 1);
        check("c5_gnt0", p0_gnt, 0);

        next_cycle();
        set_p1(1'b1, 1'b1, 8'h22, 16'hA002, 1'b0);
        #1;
        check("c6_gnt1", p1_gnt, 1);
        check("c6_gnt0", p0_gnt, 0);
        check("c6_addr", mem_addr, 8'h22);

        next_cycle();
        p1_req = 1'b0;
        #1;
        check("c7_gnt0", p0_gnt, 1);
        check("c7_addr", mem_addr, 8'h20);

        next_cycle();
        check("c8_rv0", p0_rvalid, 1);
        check("c8_rd0", p0_rdata, 16'hA000);
        p0_req = 1'b0;
        #1;
        check("c8_gnt0", p0_gnt, 0);
        check("c8_gnt1", p1_gnt, 0);
        check("c8_we", mem_we, 0);
        check("c8_addr_hold", mem_addr, 8'h20);

        // starvation: p0 locks continuously, p1 waits
        next_cycle();
        set_p0(1'b1, 1'b1, 8'h40, 16'h0001, 1'b1);
        set_p1(1'b1, 1'b0, 8'h22, 16'h0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("starve_gnt0", p0_gnt, 1);
            check("starve_gnt1", p1_gnt, 0);
`ifdef DARB_STATS_EN
            check("starve_evt_lo", starve_evt, 0);
`endif
            next_cycle();
        end
        #1;
        check("forced_gnt1", p1_gnt, 1);
        check("forced_gnt0", p0_gnt, 0);
        check("forced_addr", mem_addr, 8'h22);
`ifdef DARB_STATS_EN
        check("starve_evt_hi", starve_evt, 1);
`endif

        // back in IDLE: a lone p1 request is granted immediately
        next_cycle();
        check("c14_rv1", p1_rvalid, 1);
        check("c14_rd1", p1_rdata, 16'hA002);
        p0_req = 1'b0;
        set_p1(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0);
        #1;
        check("c14_gnt1", p1_gnt, 1);
`ifdef DARB_STATS_EN
        check("c14_evt", starve_evt, 0);
`endif

        next_cycle();
        check("c15_rv1", p1_rvalid, 1);
        check("c15_rd1", p1_rdata, 16'hBEEF);
`ifdef DARB_STATS_EN
        check("cnt0", p0_gnt_cnt, 7);
        check("cnt1", p1_gnt_cnt, 7);
`endif
        // p1 takes a locked read, then reset lands mid-burst
        set_p1(1'b1, 1'b0, 8'h11, 16'h0000, 1'b1);
        #1;
        check("c15_gnt1", p1_gnt, 1);

        next_cycle();
        rst = 1'b1;
        #1;
        check("mid_rst_gnt1", p1_gnt, 0);
        check("mid_rst_we", mem_we, 0);

        next_cycle();
        check("post_rst_rv1", p1_rvalid, 0);
`ifdef DARB_STATS_EN
        check("rst_cnt0", p0_gnt_cnt, 0);
        check("rst_cnt1", p1_gnt_cnt, 0);
`endif
        rst = 1'b0;
        set_p0(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0);
        #1;
        check("post_rst_gnt0", p0_gnt, 1);
        check("post_rst_gnt1", p1_gnt, 0);

        next_cycle();
        check("post_rst_rv0", p0_rvalid, 1);
        check("post_rst_rd0", p0_rdata, 16'hBEEF);
        set_p0(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
        set_p1(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
